// File: rtl/rv_mc_controller.sv
// -----------------------------------------------------------------------------
// rv_mc_controller
//   Multi-cycle control FSM for the RV32I core. Walks each instruction through
//   fetch / decode / execute / memory / writeback and drives every datapath
//   enable, mux select and the ALU operation code. Conditional branches are
//   resolved from the ALU zero flag in the BRANCH state.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   reset       in   synchronous active-high reset (forces FETCH)
//   op          in   instr[6:0]
//   funct3      in   instr[14:12]
//   funct7b5    in   instr[30]
//   Z           in   ALU zero flag
//   mem_ready   in   memory completes the current access this cycle
//   PCWrite     out  PC load enable
//   AdrSrc      out  memory address select: 0 PC, 1 ALUOut
//   MemWrite    out  data memory write strobe
//   IRWrite     out  IR / OldPC load enable
//   RegWrite    out  register file write enable
//   ResultSrc   out  00 ALUOut, 01 data register, 10 ALUResult
//   ALUSrcA     out  00 PC, 01 OldPC, 10 rs1, 11 zero
//   ALUSrcB     out  00 rs2, 01 immediate, 10 constant 4
//   ImmSrc      out  000 I, 001 S, 010 B, 011 J, 100 U (from op only)
//   ALUControl  out  ALU operation code
//   illegal     out  high while in TRAP
//   state_o     out  current state encoding
// -----------------------------------------------------------------------------
module rv_mc_controller #(
  parameter int ALUCW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Z,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [ALUCW-1:0] ALUControl,
  output logic             illegal,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_SGE  = 4'd10;
  localparam logic [3:0] ALU_SGEU = 4'd11;
  localparam logic [3:0] ALU_SEQ  = 4'd12;
  localparam logic [3:0] ALU_SNE  = 4'd13;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t state_q, state_d;

  // Arithmetic/logic op shared by EXECR and EXECI. funct7b5 selects SUB only
  // for register ops (for addi it is immediate bits), SRA for both.
  function automatic logic [3:0] arith_op(input logic [2:0] f3,
                                          input logic       f7b5,
                                          input logic       is_reg);
    logic [3:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // Branch compare op; the ALU yields nonzero when the branch is taken.
  function automatic logic [3:0] branch_op(input logic [2:0] f3);
    logic [3:0] r;
    r = ALU_SEQ;
    case (f3)
      3'b000:  r = ALU_SEQ;
      3'b001:  r = ALU_SNE;
      3'b100:  r = ALU_SLT;
      3'b101:  r = ALU_SGE;
      3'b110:  r = ALU_SLTU;
      default: r = ALU_SGEU;
    endcase
    return r;
  endfunction

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assign a default before the case so every path drives state_d;
    // a missing branch would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if ((op == OP_LOAD || op == OP_STORE) && funct3 == 3'b010)
          state_d = S_MEMADR;
        else if (op == OP_REG)
          state_d = S_EXECR;
        else if (op == OP_IMM)
          state_d = S_EXECI;
        else if (op == OP_BRANCH && funct3[2:1] != 2'b01)
          state_d = S_BRANCH;
        else if (op == OP_JAL)
          state_d = S_JAL;
        else if (op == OP_LUI)
          state_d = S_LUI;
        else
          state_d = S_TRAP;
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;   // sticky until reset
      default:    state_d = S_TRAP;
    endcase
  end

  // Output decode: Moore except fetch enables (mem_ready) and branch PCWrite (Z).
  logic [3:0] alu_op;

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALU_ADD;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = arith_op(funct3, funct7b5, 1'b1);
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = arith_op(funct3, funct7b5, 1'b0);
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = branch_op(funct3);
        PCWrite = ~Z;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      S_TRAP:     illegal = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end

  assign ALUControl = ALUCW'(alu_op);

  // Immediate format depends only on the opcode.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_STORE:  ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_JAL:    ImmSrc = 3'b011;
      OP_LUI:    ImmSrc = 3'b100;
      default:   ImmSrc = 3'b000;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_rv_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_rv_mc_controller
//   Self-checking bench for rv_mc_controller. A reference model expands each
//   instruction (plus its memory wait pattern) into the expected per-cycle
//   trace of state and control outputs; the bench replays it against the DUT.
// -----------------------------------------------------------------------------
module tb_rv_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       Z = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic [3:0] state_o;

  rv_mc_controller #(.ALUCW(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Z(Z), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [3:0] alu;
    logic       ill;
  } exp_t;

  exp_t q[$];

  // Operation tables indexed by funct3.
  logic [3:0] arith_tab [8] = '{4'd3, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd1, 4'd0};
  logic [3:0] br_tab    [8] = '{4'd12, 4'd13, 4'd0, 4'd0, 4'd8, 4'd10, 4'd9, 4'd11};
  logic [6:0] legal_ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                7'b1100011, 7'b1101111, 7'b0110111};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] st);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.alu = 4'd3;
    e.mr  = 1'($urandom_range(0, 1));
    return e;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'd1;
      7'b1100011: return 3'd2;
      7'b1101111: return 3'd3;
      7'b0110111: return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  // Expand one instruction into its expected cycle trace.
  task automatic build(input int fw, input int mw, output bit trap);
    exp_t e;
    trap = 0;
    q.delete();
    for (int i = 0; i <= fw; i++) begin
      e = mk(4'd0);
      e.mr = (i == fw); e.sb = 2'd2; e.rs = 2'd2; e.pcw = e.mr; e.irw = e.mr;
      q.push_back(e);
    end
    e = mk(4'd1); e.sa = 2'd1; e.sb = 2'd1; q.push_back(e);
    if ((op == 7'b0000011 || op == 7'b0100011) && funct3 == 3'b010) begin
      e = mk(4'd2); e.sa = 2'd2; e.sb = 2'd1; q.push_back(e);
      for (int i = 0; i <= mw; i++) begin
        e = mk(op[5] ? 4'd5 : 4'd3);
        e.mr = (i == mw); e.adr = 1'b1; e.mw = op[5];
        q.push_back(e);
      end
      if (!op[5]) begin
        e = mk(4'd4); e.rs = 2'd1; e.rw = 1'b1; q.push_back(e);
      end
    end else if (op == 7'b0110011 || op == 7'b0010011) begin
      e = mk(op[5] ? 4'd6 : 4'd7);
      e.sa = 2'd2; e.sb = op[5] ? 2'd0 : 2'd1;
      e.alu = arith_tab[funct3];
      if (funct3 == 3'b101 && funct7b5) e.alu = 4'd7;
      if (funct3 == 3'b000 && funct7b5 && op[5]) e.alu = 4'd4;
      q.push_back(e);
      e = mk(4'd8); e.rw = 1'b1; q.push_back(e);
    end else if (op == 7'b1100011 && funct3 != 3'b010 && funct3 != 3'b011) begin
      e = mk(4'd9); e.sa = 2'd2; e.alu = br_tab[funct3]; e.pcw = !Z;
      q.push_back(e);
    end else if (op == 7'b1101111) begin
      e = mk(4'd10); e.sa = 2'd1; e.sb = 2'd2; e.pcw = 1'b1; q.push_back(e);
      e = mk(4'd8); e.rw = 1'b1; q.push_back(e);
    end else if (op == 7'b0110111) begin
      e = mk(4'd11); e.sa = 2'd3; e.sb = 2'd1; q.push_back(e);
      e = mk(4'd8); e.rw = 1'b1; q.push_back(e);
    end else begin
      trap = 1;
      for (int i = 0; i < 12; i++) begin
        e = mk(4'd15); e.ill = 1'b1; q.push_back(e);
      end
    end
  endtask

  // Replay up to 'limit' steps of the expected trace, one per clock.
  task automatic replay(input int limit);
    for (int i = 0; i < q.size() && i < limit; i++) begin
      @(negedge clk);
      mem_ready = q[i].mr;
      #1;
      check("state",     8'(state_o),    8'(q[i].st));
      check("PCWrite",   8'(PCWrite),    8'(q[i].pcw));
      check("AdrSrc",    8'(AdrSrc),     8'(q[i].adr));
      check("MemWrite",  8'(MemWrite),   8'(q[i].mw));
      check("IRWrite",   8'(IRWrite),    8'(q[i].irw));
      check("RegWrite",  8'(RegWrite),   8'(q[i].rw));
      check("ResultSrc", 8'(ResultSrc),  8'(q[i].rs));
      check("ALUSrcA",   8'(ALUSrcA),    8'(q[i].sa));
      check("ALUSrcB",   8'(ALUSrcB),    8'(q[i].sb));
      check("ALUCtl",    8'(ALUControl), 8'(q[i].alu));
      check("illegal",   8'(illegal),    8'(q[i].ill));
      check("ImmSrc",    8'(ImmSrc),     8'(imm_of(op)));
    end
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int fw, input int mw);
    bit trap;
    op = o; funct3 = f3; funct7b5 = f7; Z = z;
    build(fw, mw, trap);
    replay(q.size());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rst_state",   8'(state_o),    8'd0);
    check("rst_MemWr",   8'(MemWrite),   8'd0);
    check("rst_illegal", 8'(illegal),    8'd0);
    check("rst_ALUCtl",  8'(ALUControl), 8'd3);
    check("rst_PCWr_hi", 8'(PCWrite),    8'd1);
    check("rst_IRWr_hi", 8'(IRWrite),    8'd1);
    check("rst_RegWr",   8'(RegWrite),   8'd0);
    mem_ready = 1'b0;
    #1;
    check("rst_PCWr_lo", 8'(PCWrite),    8'd0);
    check("rst_IRWr_lo", 8'(IRWrite),    8'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit trap;
    do_reset();

    // Reset mid-way through a waiting store.
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Z = 1'b0;
    build(0, 6, trap);
    replay(5);                 // FETCH, DECODE, MEMADR, MEMWRITE, MEMWRITE
    do_reset();

    // Directed instructions.
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);  // add
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);  // sub
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2);  // lw, 2 wait cycles
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1, 1);  // sw, fetch + mem waits
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);  // beq Z=0
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);  // beq Z=1
    run_instr(7'b1100011, 3'b110, 1'b0, 1'b0, 0, 0);  // bltu
    run_instr(7'b0010011, 3'b101, 1'b1, 1'b0, 0, 0);  // srai
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);  // addi, bit30 set
    run_instr(7'b1101111, 3'b011, 1'b0, 1'b0, 2, 0);  // jal
    run_instr(7'b0110111, 3'b111, 1'b1, 1'b1, 0, 0);  // lui

    // Random legal instructions.
    for (int n = 0; n < 60; n++) begin
      do begin
        op       = legal_ops[$urandom_range(0, 6)];
        funct3   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b010;
        if (op != 7'b0000011 && op != 7'b0100011) funct3 = 3'($urandom);
        funct7b5 = 1'($urandom);
        Z        = 1'($urandom);
        build($urandom_range(0, 2), $urandom_range(0, 2), trap);
      end while (trap);
      replay(q.size());
    end

    // Illegal opcode: TRAP sticky, then cleared by reset.
    run_instr(7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0);
    do_reset();
    // Branch with reserved funct3.
    run_instr(7'b1100011, 3'b010, 1'b0, 1'b0, 1, 0);
    do_reset();
    // Load with non-word funct3.
    run_instr(7'b0000011, 3'b000, 1'b0, 1'b0, 0, 0);
    do_reset();
    run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0);  // and, after trap recovery

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_mc_controller.md
# rv_mc_controller

Multi-cycle control FSM for the RV32I core: sequences each instruction through fetch, decode, execute, memory and writeback states and drives every datapath enable, mux select and the 4-bit ALU operation code consumed by the ALU. It is the producer side of the ALU control interface. It evaluates the ALU zero flag to resolve conditional branches. It sits between instruction/data memory handshake and the shared datapath (PC, IR, register file, ALUOut, data register).

## Interface
- ALUCW, 4, width of ALU operation code
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- op  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- Z  in  1  ALU zero flag (ALUResult == 0)
- mem_ready  in  1  memory completes current access this cycle
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  IR and OldPC load enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 ALUOut, 01 data register, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- ALUSrcB  out  2  00 rs2, 01 immediate, 10 constant 4
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational from op)
- ALUControl  out  ALUCW  0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 SGE, 11 SGEU, 12 SEQ, 13 SNE
- illegal  out  1  high while in TRAP
- state_o  out  4  current state encoding (debug)

## Operation
- State register only; all outputs Moore-decoded from state, except IRWrite/PCWrite in FETCH, PCWrite in BRANCH and ImmSrc.
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11, TRAP 15.
- Defaults every state: all enables 0, selects 00, ALUControl = ADD.
- FETCH: AdrSrc 0, SrcA 00, SrcB 10, ADD, ResultSrc 10; IRWrite = PCWrite = mem_ready; go DECODE on mem_ready, else hold.
- DECODE: SrcA 01, SrcB 01, ADD (branch/jump target into ALUOut). Next: lw/sw (0000011/0100011, funct3 = 010) -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 with funct3 not 010/011 -> BRANCH; 1101111 -> JAL; 0110111 -> LUI; anything else -> TRAP.
- MEMADR: SrcA 10, SrcB 01, ADD; op bit 5 = 0 -> MEMREAD, 1 -> MEMWRITE.
- MEMREAD: AdrSrc 1; hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc 01, RegWrite 1 -> FETCH.
- MEMWRITE: AdrSrc 1, MemWrite 1 (held while waiting); on mem_ready -> FETCH.
- EXECR: SrcA 10, SrcB 00; funct3 000 ADD (SUB if funct7b5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7b5), 110 OR, 111 AND -> ALUWB.
- EXECI: SrcA 10, SrcB 01; same map but 000 always ADD, funct7b5 only honoured for 101 -> ALUWB.
- ALUWB: ResultSrc 00, RegWrite 1 -> FETCH.
- BRANCH: SrcA 10, SrcB 00; funct3 000 SEQ, 001 SNE, 100 SLT, 101 SGE, 110 SLTU, 111 SGEU; ResultSrc 00; PCWrite = !Z (taken when compare result nonzero) -> FETCH.
- JAL: SrcA 01, SrcB 10, ADD, ResultSrc 00, PCWrite 1 -> ALUWB (writes PC+4 to rd).
- LUI: SrcA 11, SrcB 01, ADD -> ALUWB.
- TRAP: illegal 1, all enables 0; sticky until reset.

## Timing
- reset sampled on clk edge; next state FETCH regardless of current state (aborts MEMREAD/MEMWRITE mid-wait; MemWrite drops the following cycle).
- Outputs while reset asserted and after: FETCH decode; PCWrite/IRWrite follow mem_ready, all others 0, ALUControl 3, illegal 0, state_o 0.
- Cycles with zero wait states: R/I/LUI/JAL 4, lw 5, sw 4, branch 3. Each cycle mem_ready is low in FETCH/MEMREAD/MEMWRITE adds one cycle.
- Z used only in BRANCH, same cycle, no registering.

## Test plan
- Reset from arbitrary state (e.g. MEMWRITE waiting) -> state_o 0, MemWrite 0, illegal 0 next cycle.
- add then sub (op 0110011, funct3 000, funct7b5 0/1), mem_ready=1 -> states 0,1,6,8; ALUControl 3 then 4 in EXECR; RegWrite pulse in ALUWB; 4 cycles each.
- lw with mem_ready low 2 cycles in MEMREAD -> 0,1,2,3,3,3,4; RegWrite 1 with ResultSrc 01 only in MEMWB; total 7 cycles.
- beq funct3 000: Z=0 -> PCWrite 1 and ALUControl 12; Z=1 -> PCWrite 0; bltu funct3 110 -> ALUControl 9.
- srai (0010011, 101, funct7b5 1) -> ALUControl 7; addi with funct7b5 1 -> ALUControl 3.
- op 1110011 or branch funct3 010 -> TRAP, illegal 1 held 10+ cycles, no enables, cleared only by reset.
